// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds x/y from incoming h_sync/v_sync,
// opens a frame_active window once timing is locked, and counts violations.
module vga_sync_decoder #(
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_active,
  output logic       locked,
  output logic       frame_start,
  output logic [7:0] err_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SS    = H_VISIBLE + H_FRONT;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SS    = V_VISIBLE + V_FRONT;

  localparam logic [9:0]  HC_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VC_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HC_SS    = 10'(H_SS);
  localparam logic [9:0]  HC_ALIGN = 10'(H_SS + 1);
  localparam logic [9:0]  VC_SS    = 10'(V_SS);
  localparam logic [9:0]  HC_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0]  VC_VIS   = 10'(V_VISIBLE);
  localparam logic [10:0] WD_LIMIT = 11'(2 * H_TOTAL);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  logic        r_hs_prev, r_vs_prev;
  logic [9:0]  r_hcnt, r_vcnt;
  logic [10:0] r_wd;
  logic        r_line_err;
  state_t      r_state;
  logic        r_locked;
  logic [7:0]  r_err;

  logic       w_hs_asrt, w_vs_asrt, w_hs_edge, w_vs_edge;
  logic       w_hwrap, w_vwrap;
  logic [9:0] w_hn, w_vn, w_hcnt_nxt, w_vcnt_nxt;
  logic       w_h_good, w_v_good, w_bad_h, w_bad_v, w_wd_exp;
  logic [7:0] w_err_inc;

  // Normalise polarity so everything below works on "asserted" levels.
  assign w_hs_asrt = SYNC_ACTIVE_LOW ? ~h_sync : h_sync;
  assign w_vs_asrt = SYNC_ACTIVE_LOW ? ~v_sync : v_sync;
  assign w_hs_edge = w_hs_asrt & ~r_hs_prev;
  assign w_vs_edge = w_vs_asrt & ~r_vs_prev;

  // Free-running next values of the raster counters.
  assign w_hwrap = (r_hcnt == HC_LAST);
  assign w_vwrap = (r_vcnt == VC_LAST);
  assign w_hn    = w_hwrap ? 10'd0 : r_hcnt + 10'd1;
  assign w_vn    = w_hwrap ? (w_vwrap ? 10'd0 : r_vcnt + 10'd1) : r_vcnt;

  // A sync edge realigns its counter; v edge beats the h wrap on a tie.
  assign w_hcnt_nxt = w_hs_edge ? HC_ALIGN : w_hn;
  assign w_vcnt_nxt = w_vs_edge ? VC_SS    : w_vn;

  // The h edge is on time when the count sitting at the edge cycle is H_SS,
  // i.e. the free-running next value already equals the realign target.
  assign w_h_good = (r_hcnt == HC_SS);
  assign w_v_good = (w_vn == VC_SS);
  assign w_bad_h  = w_hs_edge & ~w_h_good;
  assign w_bad_v  = w_vs_edge & ~w_v_good;
  assign w_wd_exp = (r_wd == WD_LIMIT);

  assign w_err_inc = (r_err == 8'hFF) ? r_err : r_err + 8'd1;

  assign x            = r_hcnt;
  assign y            = r_vcnt;
  assign locked       = r_locked;
  assign err_count    = r_err;
  assign frame_active = r_locked && (r_hcnt < HC_VIS) && (r_vcnt < VC_VIS);
  assign frame_start  = r_locked && (r_hcnt == 10'd0) && (r_vcnt == 10'd0);

  // Previous-cycle sync samples for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
    end else begin
      r_hs_prev <= w_hs_asrt;
      r_vs_prev <= w_vs_asrt;
    end
  end

  // Raster counters, realigned by the sync edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
    end
  end

  // Missing-hsync watchdog; parks at the limit so expiry stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_wd <= 11'd0;
    else if (w_hs_edge)  r_wd <= 11'd0;
    else if (!w_wd_exp)  r_wd <= r_wd + 11'd1;
  end

  // Remembers a mistimed line within the current frame; a bad edge wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_line_err <= 1'b0;
    else if (w_bad_h)   r_line_err <= 1'b1;
    else if (w_vs_edge) r_line_err <= 1'b0;
  end

  // Lock FSM with registered lock flag and saturating violation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_SEARCH;
      r_locked <= 1'b0;
      r_err    <= 8'd0;
    end else if (w_wd_exp) begin
      r_state  <= S_SEARCH;
      r_locked <= 1'b0;
      if (r_state != S_SEARCH) r_err <= w_err_inc;
    end else begin
      case (r_state)
        S_SEARCH: begin
          if (w_vs_edge) r_state <= S_TRACK;
        end
        S_TRACK: begin
          if (w_bad_h || w_bad_v) r_err <= w_err_inc;
          if (w_vs_edge && w_v_good && !r_line_err && !w_bad_h) begin
            r_state  <= S_LOCKED;
            r_locked <= 1'b1;
          end
        end
        S_LOCKED: begin
          if (w_bad_h || w_bad_v) begin
            r_state  <= S_TRACK;
            r_locked <= 1'b0;
            r_err    <= w_err_inc;
          end
        end
        default: begin
          r_state  <= S_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a scaled raster source drives an active-low and
// an active-high instance; both are compared every cycle to a reference model.
module tb_vga_sync_decoder;

  localparam int HV = 32, HF = 4, HSW = 6, HBK = 8;
  localparam int VV = 16, VF = 2, VSW = 2, VBK = 4;
  localparam int HT  = HV + HF + HSW + HBK;
  localparam int HSS = HV + HF;
  localparam int VT  = VV + VF + VSW + VBK;
  localparam int VSS = VV + VF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hs_l, vs_l, hs_h, vs_h;
  logic [9:0] x0, y0, x1, y1;
  logic fa0, lk0, fs0, fa1, lk1, fs1;
  logic [7:0] err0, err1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_sync_decoder #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBK),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBK), .SYNC_ACTIVE_LOW(1'b1))
  u_lo (.clk(clk), .rst_n(rst_n), .h_sync(hs_l), .v_sync(vs_l), .x(x0), .y(y0),
    .frame_active(fa0), .locked(lk0), .frame_start(fs0), .err_count(err0));

  vga_sync_decoder #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBK),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBK), .SYNC_ACTIVE_LOW(1'b0))
  u_hi (.clk(clk), .rst_n(rst_n), .h_sync(hs_h), .v_sync(vs_h), .x(x1), .y(y1),
    .frame_active(fa1), .locked(lk1), .frame_start(fs1), .err_count(err1));

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- raster source ----------------
  int sh, sv, llen, short_lines;
  bit en_h, s_hs, s_vs;

  task automatic src_drive();
    s_hs = en_h && (sh >= HSS) && (sh < HSS + HSW);
    s_vs = (sv >= VSS) && (sv < VSS + VSW);
    hs_l = !s_hs; vs_l = !s_vs;
    hs_h = s_hs;  vs_h = s_vs;
  endtask

  task automatic src_adv();
    if (sh >= llen - 1) begin
      sh = 0;
      sv = (sv + 1) % VT;
      if (short_lines > 0) begin llen = HT - 1; short_lines--; end
      else llen = HT;
    end else sh++;
    src_drive();
  endtask

  // ---------------- reference model ----------------
  int m_st, m_hc, m_vc, m_wd, m_err;   // m_st: 0 search, 1 track, 2 locked
  bit m_phs, m_pvs, m_le, m_ve;

  task automatic model_reset();
    m_st = 0; m_hc = 0; m_vc = 0; m_wd = 0; m_err = 0;
    m_phs = 0; m_pvs = 0; m_le = 0; m_ve = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit he, ve, bh, bv, wexp;
    int hn, vn, st;
    he = hs && !m_phs;
    ve = vs && !m_pvs;
    hn = (m_hc + 1) % HT;
    vn = (m_hc == HT - 1) ? (m_vc + 1) % VT : m_vc;
    bh = he && (m_hc != HSS);
    bv = ve && (vn != VSS);
    wexp = (m_wd >= 2 * HT);
    st = m_st;
    if (wexp) begin
      if (m_st != 0) m_err = (m_err < 255) ? m_err + 1 : 255;
      st = 0;
    end else if (m_st == 0) begin
      if (ve) st = 1;
    end else begin
      if (bh || bv) m_err = (m_err < 255) ? m_err + 1 : 255;
      if (m_st == 1 && ve && !bv && !bh && !m_le) st = 2;
      else if (m_st == 2 && (bh || bv)) st = 1;
    end
    m_le  = bh ? 1'b1 : (ve ? 1'b0 : m_le);
    m_wd  = he ? 0 : (wexp ? m_wd : m_wd + 1);
    m_hc  = he ? HSS + 1 : hn;
    m_vc  = ve ? VSS : vn;
    m_phs = hs; m_pvs = vs; m_ve = ve; m_st = st;
  endtask

  task automatic check_all();
    int lk, fa, fs;
    lk = (m_st == 2) ? 1 : 0;
    fa = (lk == 1 && m_hc < HV && m_vc < VV) ? 1 : 0;
    fs = (lk == 1 && m_hc == 0 && m_vc == 0) ? 1 : 0;
    chk("x_lo", x0, m_hc);    chk("x_hi", x1, m_hc);
    chk("y_lo", y0, m_vc);    chk("y_hi", y1, m_vc);
    chk("lock_lo", lk0, lk);  chk("lock_hi", lk1, lk);
    chk("fa_lo", fa0, fa);    chk("fa_hi", fa1, fa);
    chk("fs_lo", fs0, fs);    chk("fs_hi", fs1, fs);
    chk("err_lo", err0, m_err); chk("err_hi", err1, m_err);
  endtask

  // One clock: model consumes the inputs sampled at the edge, outputs are
  // checked 1 time unit later, then the source moves to its next position.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(s_hs, s_vs);
    #1;
    check_all();
    src_adv();
  endtask

  task automatic wait_lock(input string tag, input int budget);
    int nve, yv;
    bit ok, got_y;
    nve = 0; yv = -1; ok = 0; got_y = 0;
    for (int i = 0; i < budget; i++) begin
      cyc();
      if (m_ve) begin
        nve++;
        if (!got_y) begin got_y = 1; yv = y0; end
      end
      if (lk0) begin ok = 1; break; end
    end
    chk({tag, "_locked"}, ok, 1);
    chk({tag, "_locked_hi"}, lk1, 1);
    chk({tag, "_vs_edges"}, nve, 2);
    chk({tag, "_y_first_vs"}, yv, VSS);
  endtask

  task automatic wait_sh(input int t);
    for (int i = 0; i < 2 * HT && sh != t; i++) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int nfs0, nfs1, e, ok;
    en_h = 1; short_lines = 0; llen = HT;
    sv = $urandom_range(VSS - 3, 0);
    sh = $urandom_range(HT - 1, 0);
    src_drive();
    model_reset();

    // reset state
    repeat (3) cyc();
    chk("rst_x", x0, 0); chk("rst_y", y0, 0); chk("rst_lock", lk0, 0);
    chk("rst_fa", fa0, 0); chk("rst_fs", fs0, 0); chk("rst_err", err0, 0);

    // clean stream: lock at second v edge, one frame_start per frame
    rst_n = 1'b1;
    wait_lock("clean", 4 * HT * VT);
    nfs0 = 0; nfs1 = 0;
    repeat (3 * HT * VT) begin cyc(); nfs0 += fs0; nfs1 += fs1; end
    chk("clean_fs_lo", nfs0, 3);
    chk("clean_fs_hi", nfs1, 3);
    chk("clean_err", err0, 0);
    chk("clean_lock", lk0, 1);

    // one short line drops lock with a single error, relocks on a good pair
    wait_sh(0);
    short_lines = 1;
    ok = 0;
    for (int i = 0; i < 3 * HT; i++) begin
      cyc();
      if (!lk0) begin ok = 1; break; end
    end
    chk("short_drop", ok, 1);
    chk("short_err", err0, 1);
    wait_lock("short_relock", 4 * HT * VT);

    // h_sync removed past the watchdog limit
    wait_sh(HSS + HSW);
    e = err0;
    en_h = 0; src_drive();
    repeat (2 * HT + 20) cyc();
    chk("wd_lock", lk0, 0);
    chk("wd_fa", fa0, 0);
    chk("wd_err", err0, e + 1);
    en_h = 1; src_drive();
    wait_lock("wd_relock", 4 * HT * VT);

    // asynchronous reset mid-line while locked
    repeat ($urandom_range(3 * HT, 5)) cyc();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_x", x0, 0); chk("arst_y", y0, 0); chk("arst_lock", lk0, 0);
    chk("arst_fa", fa0, 0); chk("arst_fs", fs0, 0); chk("arst_err", err0, 0);
    chk("arst_x_hi", x1, 0); chk("arst_lock_hi", lk1, 0);
    model_reset();
    for (int i = 0; i < HT * VT + HT && sv != 1; i++) cyc();
    repeat ($urandom_range(HT - 2, 0)) cyc();
    rst_n = 1'b1;
    cyc();
    chk("arst_unlocked", lk0, 0);
    wait_lock("arst_relock", 4 * HT * VT);

    // a long run of bad lines saturates the error counter
    short_lines = 300;
    repeat (300 * HT + 4 * HT) cyc();
    chk("sat_err_lo", err0, 255);
    chk("sat_err_hi", err1, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
